laser_point_loader: RTL

- Front stage of the LASER two-circle coverage engine. Captures the NUM_PTS target coordinates streamed in after reset into an internal point store.
- Then serves coverage-count queries from the downstream search FSM. Each query gives a candidate circle centre and an optional exclusion centre. The block returns how many stored points lie inside the candidate circle and outside the exclusion circle.

---
 rtl/laser_point_loader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/laser_point_loader.sv
// laser_point_loader
// Front stage of the LASER two-circle coverage engine. After reset the block
// captures NUM_PTS streamed (X,Y) points, one per clock. It then answers
// coverage queries: for each stored point it tests membership in the
// candidate circle and, if enabled, in the exclusion circle. It returns how
// many points are covered by the candidate circle and not by the exclusion
// circle. One point is evaluated per cycle.
module laser_point_loader #(
  parameter int NUM_PTS   = 40,
  parameter int RADIUS_SQ = 16,
  parameter int CW        = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  output logic          load_done,
  input  logic          q_valid,
  output logic          q_ready,
  input  logic [CW-1:0] q_cx,
  input  logic [CW-1:0] q_cy,
  input  logic          q_excl_en,
  input  logic [CW-1:0] q_ex,
  input  logic [CW-1:0] q_ey,
  output logic          r_valid,
  output logic [5:0]    r_count
);

  localparam int IW = (NUM_PTS > 1) ? $clog2(NUM_PTS) : 1;
  // The sum of two squares needs one bit more than a single square.
  localparam int SW = 2 * CW + 1;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SCAN   = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;

  logic [IW-1:0] idx_r;
  logic          idx_last_s;
  logic [5:0]    acc_r;

  logic [CW-1:0] cx_r;
  logic [CW-1:0] cy_r;
  logic          excl_r;
  logic [CW-1:0] ex_r;
  logic [CW-1:0] ey_r;

  logic [CW-1:0] px_r [NUM_PTS];
  logic [CW-1:0] py_r [NUM_PTS];

  logic          pt_in_s;
  logic          ex_in_s;
  logic          hit_s;

  logic          load_done_r;
  logic          q_ready_r;
  logic          r_valid_r;
  logic [5:0]    r_count_r;
  logic          load_done_s;
  logic          q_ready_s;
  logic          r_valid_s;
  logic [5:0]    r_count_s;

  // Squared-distance test. The result is full width, so the distance 450
  // (15^2 + 15^2) cannot wrap. A point on the boundary counts as inside.
  function automatic logic in_circle(
    input logic [CW-1:0] px,
    input logic [CW-1:0] py,
    input logic [CW-1:0] cx,
    input logic [CW-1:0] cy
  );
    logic [CW-1:0]   dx;
    logic [CW-1:0]   dy;
    logic [2*CW-1:0] dx2;
    logic [2*CW-1:0] dy2;
    logic [SW-1:0]   sum;
    dx  = (px >= cx) ? (px - cx) : (cx - px);
    dy  = (py >= cy) ? (py - cy) : (cy - py);
    dx2 = {{CW{1'b0}}, dx} * {{CW{1'b0}}, dx};
    dy2 = {{CW{1'b0}}, dy} * {{CW{1'b0}}, dy};
    sum = {1'b0, dx2} + {1'b0, dy2};
    return (sum <= SW'(RADIUS_SQ));
  endfunction

  assign idx_last_s = (idx_r == IW'(NUM_PTS - 1));

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: load once, then loop IDLE -> SCAN -> RESULT -> IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (idx_last_s) state_s = ST_IDLE;
        else            state_s = ST_LOAD;
      end
      ST_IDLE: begin
        if (q_valid) state_s = ST_SCAN;
        else         state_s = ST_IDLE;
      end
      ST_SCAN: begin
        if (idx_last_s) state_s = ST_SCAN == ST_SCAN ? ST_RESULT : ST_SCAN;
        else            state_s = ST_SCAN;
      end
      ST_RESULT: state_s = ST_IDLE;
      default:   state_s = ST_LOAD;
    endcase
  end

  // Output decode. The outputs are registered, so q_ready and load_done are
  // derived from the next state. r_valid and r_count are taken from the
  // RESULT cycle and appear one edge later.
  always_comb begin
    load_done_s = (state_s != ST_LOAD);
    q_ready_s   = (state_s == ST_IDLE);
    r_valid_s   = (state_r == ST_RESULT);
    if (state_r == ST_RESULT) begin
      r_count_s = acc_r;
    end else begin
      r_count_s = r_count_r;
    end
  end

  // Output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      load_done_r <= 1'b0;
      q_ready_r   <= 1'b0;
      r_valid_r   <= 1'b0;
      r_count_r   <= 6'd0;
    end else begin
      load_done_r <= load_done_s;
      q_ready_r   <= q_ready_s;
      r_valid_r   <= r_valid_s;
      r_count_r   <= r_count_s;
    end
  end

  // Index, accumulator and the query latch. Query fields are captured only
  // on the accepting edge, so later changes on the query inputs are ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_r  <= IW'(0);
      acc_r  <= 6'd0;
      cx_r   <= {CW{1'b0}};
      cy_r   <= {CW{1'b0}};
      excl_r <= 1'b0;
      ex_r   <= {CW{1'b0}};
      ey_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_LOAD: begin
          idx_r <= idx_last_s ? IW'(0) : idx_r + IW'(1);
        end
        ST_IDLE: begin
          if (q_valid) begin
            cx_r   <= q_cx;
            cy_r   <= q_cy;
            excl_r <= q_excl_en;
            ex_r   <= q_ex;
            ey_r   <= q_ey;
            acc_r  <= 6'd0;
            idx_r  <= IW'(0);
          end
        end
        ST_SCAN: begin
          acc_r <= acc_r + {5'd0, hit_s};
          idx_r <= idx_last_s ? IW'(0) : idx_r + IW'(1);
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // Point store. The contents are undefined after reset and need no reset.
  always_ff @(posedge CLK) begin
    if (!RST && (state_r == ST_LOAD)) begin
      px_r[idx_r] <= X;
      py_r[idx_r] <= Y;
    end
  end

  // Coverage decision for the point at the current scan index.
  always_comb begin
    pt_in_s = in_circle(px_r[idx_r], py_r[idx_r], cx_r, cy_r);
    ex_in_s = in_circle(px_r[idx_r], py_r[idx_r], ex_r, ey_r);
    hit_s   = pt_in_s & ~(excl_r & ex_in_s);
  end

  assign load_done = load_done_r;
  assign q_ready   = q_ready_r;
  assign r_valid   = r_valid_r;
  assign r_count   = r_count_r;

endmodule
